nvm_cmd_scheduler: RTL and testbench
====================================

Name: nvm_cmd_scheduler

Overview:
- Sits between several memory-traffic requesters and the NVMain VPI command harness (command_enable / arg0..arg4 / is_issuable).
- Picks one request at a time by round-robin.
- Sends the lowercase query opcode, polls is_issuable, then sends the uppercase issue opcode.
- Retries queries that time out and drops a request after a bounded number of retries.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- RESP_MASK, 2, cycles after a query during which is_issuable is ignored (harness pipeline plus flag-clear latency).
- RESP_WAIT, 6, cycles after a query within which is_issuable must rise; must be > RESP_MASK.
- MAX_RETRY, 3, re-queries allowed before a request is dropped.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request pending
- req_ready  out  NUM_REQ  one-cycle accept pulse to the granted requester
- req_op  in  2*NUM_REQ  per-requester opcode: 0=load('l'/'L'), 1=write('w'/'W'), 2=read('r'/'R'), 3=cmd('c'/'C')
- req_arg1, req_arg2, req_arg3  in  32*NUM_REQ each  per-requester arguments, slice i = [32*i+31:32*i]
- req_arg4  in  8*NUM_REQ  per-requester byte argument
- command_enable  out  1  command strobe to harness
- arg0  out  8  ASCII opcode
- arg1, arg2, arg3  out  32 each  latched arguments
- arg4  out  8  latched byte argument
- is_issuable  in  1  harness issuable flag
- done_valid  out  1  one-cycle pulse: request issued
- err_valid  out  1  one-cycle pulse: request dropped
- resp_id  out  3  requester index for done_valid/err_valid

Behaviour:
- All outputs registered.
- Reset values: req_ready=0, command_enable=0, arg0..arg4=0, done_valid=0, err_valid=0, resp_id=0, state=IDLE, rr pointer=NUM_REQ-1 (requester 0 wins first), retry counter=0, wait counter=0.
- Reset mid-operation aborts the in-flight request silently: no done_valid, no err_valid.
- When command_enable=0, arg0..arg4 drive 0.
- IDLE:
  - If any req_valid, grant the first set index searching upward from rr+1 with wrap.
  - Latch that requester's op/args and pulse req_ready[g]=1 for that single cycle.
  - rr<=g, retry<=0, go to QUERY.
  - Requests arriving while busy wait; req_valid must be held until req_ready.
- QUERY (1 cycle):
  - command_enable=1, arg0 = 0x6C/0x77/0x72/0x63 for op 0/1/2/3, arg1..arg4 = latched values.
  - wait counter <= 0, go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - is_issuable is ignored while counter < RESP_MASK.
  - If is_issuable=1 with counter >= RESP_MASK, go to ISSUE.
  - Else, when counter reaches RESP_WAIT-1:
    - If retry==MAX_RETRY: err_valid=1 and resp_id=g next cycle, go to IDLE.
    - Otherwise retry++ and go to QUERY.
- ISSUE (1 cycle):
  - command_enable=1, arg0 = 0x4C/0x57/0x52/0x43, same args.
  - done_valid=1 and resp_id=g in the same cycle; go to IDLE.
- Latency, uncontended, is_issuable rising at counter=RESP_MASK: req_valid seen in cycle 0 gives req_ready in cycle 0, query in cycle 1, issue in cycle 1+RESP_MASK+2, next grant the cycle after.
- Throughput: at most one command_enable per cycle, never back-to-back query and issue.
- Stale-flag rule: after ISSUE, the harness clears its flag two cycles later. RESP_MASK>=2 guarantees a stale high is never taken as a response to the next query.
- Grant pointer wraps NUM_REQ-1 to 0.
- resp_id is zero-extended.

Test Plan:
- Single request, req 0 op=2, arg1=0x00001000, arg2=0, arg3=0, arg4=0x01; is_issuable rises 3 cycles after query.
  - Expect command_enable pulses with arg0=0x72 then 0x52, args carried unchanged, done_valid with resp_id=0.
- All 4 requesters valid continuously, each answered immediately after the mask.
  - Expect grant order 0,1,2,3,0 and done_valid resp_id sequence 0,1,2,3,0.
- is_issuable never rises, MAX_RETRY=3, req 2 op=1.
  - Expect exactly 4 pulses with arg0=0x77, each RESP_WAIT cycles apart.
  - Then err_valid=1 with resp_id=2, no 0x57, then IDLE.
- is_issuable held high from reset.
  - Expect it ignored for RESP_MASK cycles after the query.
  - ISSUE occurs no earlier than query+RESP_MASK+1.
- is_issuable rises on the 2nd retry (3rd query), op=3.
  - Expect query arg0=0x63 three times, then 0x43, then done_valid.
  - Expect no err_valid.
- reset asserted in WAIT with req 1 in flight.
  - Next cycle: all outputs 0, state IDLE, no done_valid/err_valid.
  - The first grant after reset goes to requester 0 if valid.

Source files
------------

// File: rtl/nvm_cmd_scheduler_if.sv
// Bundle of requester-side and harness-side signals for nvm_cmd_scheduler.
// master: the scheduler's view. slave: the requesters and the NVMain harness.
interface nvm_cmd_scheduler_if #(
    parameter int unsigned NUM_REQ = 4
);
    // requester side
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [2*NUM_REQ-1:0]  req_op;
    logic [32*NUM_REQ-1:0] req_arg1;
    logic [32*NUM_REQ-1:0] req_arg2;
    logic [32*NUM_REQ-1:0] req_arg3;
    logic [8*NUM_REQ-1:0]  req_arg4;

    // harness side
    logic                  command_enable;
    logic [7:0]            arg0;
    logic [31:0]           arg1;
    logic [31:0]           arg2;
    logic [31:0]           arg3;
    logic [7:0]            arg4;
    logic                  is_issuable;

    // completion reporting
    logic                  done_valid;
    logic                  err_valid;
    logic [2:0]            resp_id;

    modport master (
        input  req_valid, req_op, req_arg1, req_arg2, req_arg3, req_arg4,
        input  is_issuable,
        output req_ready,
        output command_enable, arg0, arg1, arg2, arg3, arg4,
        output done_valid, err_valid, resp_id
    );

    modport slave (
        output req_valid, req_op, req_arg1, req_arg2, req_arg3, req_arg4,
        output is_issuable,
        input  req_ready,
        input  command_enable, arg0, arg1, arg2, arg3, arg4,
        input  done_valid, err_valid, resp_id
    );
endinterface

// File: rtl/nvm_cmd_scheduler.sv
// Round-robin command scheduler in front of the NVMain VPI command harness.
// Grants one requester at a time, sends the lowercase query opcode, polls
// is_issuable (ignoring it for RESP_MASK cycles), then sends the uppercase
// issue opcode. Unanswered queries are retried up to MAX_RETRY times, after
// which the request is dropped and reported on err_valid.
module nvm_cmd_scheduler #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned RESP_MASK = 2,
    parameter int unsigned RESP_WAIT = 6,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    nvm_cmd_scheduler_if.master  bus
);
    localparam int unsigned IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CW  = $clog2(RESP_WAIT + 1);
    localparam int unsigned RW  = $clog2(MAX_RETRY + 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_QUERY,
        S_WAIT,
        S_ISSUE
    } state_t;

    state_t              state_q;
    logic [IDW-1:0]      rr_q;
    logic [IDW-1:0]      gnt_q;
    logic [1:0]          op_q;
    logic [31:0]         a1_q;
    logic [31:0]         a2_q;
    logic [31:0]         a3_q;
    logic [7:0]          a4_q;
    logic [CW-1:0]       cnt_q;
    logic [RW-1:0]       retry_q;

    logic [NUM_REQ-1:0]  req_ready_q;
    logic                ce_q;
    logic [7:0]          arg0_q;
    logic [31:0]         arg1_q;
    logic [31:0]         arg2_q;
    logic [31:0]         arg3_q;
    logic [7:0]          arg4_q;
    logic                done_q;
    logic                err_q;
    logic [2:0]          resp_id_q;

    logic [IDW-1:0]      gnt_d;
    logic                gnt_hit_d;

    assign bus.req_ready      = req_ready_q;
    assign bus.command_enable = ce_q;
    assign bus.arg0           = arg0_q;
    assign bus.arg1           = arg1_q;
    assign bus.arg2           = arg2_q;
    assign bus.arg3           = arg3_q;
    assign bus.arg4           = arg4_q;
    assign bus.done_valid     = done_q;
    assign bus.err_valid      = err_q;
    assign bus.resp_id        = resp_id_q;

    // Lowercase query opcode; the issue opcode is its uppercase form.
    function automatic logic [7:0] op_char(input logic [1:0] op);
        case (op)
            2'd0:    return 8'h6C;
            2'd1:    return 8'h77;
            2'd2:    return 8'h72;
            default: return 8'h63;
        endcase
    endfunction

    // Round-robin search: first valid requester upward from rr_q+1, wrapping.
    always_comb begin
        int unsigned idx;
        gnt_d     = '0;
        gnt_hit_d = 1'b0;
        idx       = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = 32'(rr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!gnt_hit_d && bus.req_valid[idx[IDW-1:0]]) begin
                gnt_hit_d = 1'b1;
                gnt_d     = idx[IDW-1:0];
            end
        end
    end

    // Scheduler FSM with registered harness/requester outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rr_q        <= IDW'(NUM_REQ - 1);
            gnt_q       <= '0;
            op_q        <= '0;
            a1_q        <= '0;
            a2_q        <= '0;
            a3_q        <= '0;
            a4_q        <= '0;
            cnt_q       <= '0;
            retry_q     <= '0;
            req_ready_q <= '0;
            ce_q        <= 1'b0;
            arg0_q      <= '0;
            arg1_q      <= '0;
            arg2_q      <= '0;
            arg3_q      <= '0;
            arg4_q      <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            resp_id_q   <= '0;
        end else begin
            req_ready_q <= '0;
            ce_q        <= 1'b0;
            arg0_q      <= '0;
            arg1_q      <= '0;
            arg2_q      <= '0;
            arg3_q      <= '0;
            arg4_q      <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (gnt_hit_d) begin
                        req_ready_q[gnt_d] <= 1'b1;
                        gnt_q   <= gnt_d;
                        rr_q    <= gnt_d;
                        retry_q <= '0;
                        op_q    <= bus.req_op[2*gnt_d +: 2];
                        a1_q    <= bus.req_arg1[32*gnt_d +: 32];
                        a2_q    <= bus.req_arg2[32*gnt_d +: 32];
                        a3_q    <= bus.req_arg3[32*gnt_d +: 32];
                        a4_q    <= bus.req_arg4[8*gnt_d +: 8];
                        state_q <= S_QUERY;
                    end
                end

                S_QUERY: begin
                    ce_q    <= 1'b1;
                    arg0_q  <= op_char(op_q);
                    arg1_q  <= a1_q;
                    arg2_q  <= a2_q;
                    arg3_q  <= a3_q;
                    arg4_q  <= a4_q;
                    cnt_q   <= '0;
                    state_q <= S_WAIT;
                end

                S_WAIT: begin
                    if (bus.is_issuable && (32'(cnt_q) >= RESP_MASK)) begin
                        state_q <= S_ISSUE;
                    end else if (32'(cnt_q) == RESP_WAIT - 1) begin
                        if (32'(retry_q) == MAX_RETRY) begin
                            err_q     <= 1'b1;
                            resp_id_q <= 3'(gnt_q);
                            state_q   <= S_IDLE;
                        end else begin
                            // Re-query emitted straight from WAIT (folding the
                            // QUERY cycle) so retries sit RESP_WAIT cycles apart.
                            retry_q <= retry_q + 1'b1;
                            ce_q    <= 1'b1;
                            arg0_q  <= op_char(op_q);
                            arg1_q  <= a1_q;
                            arg2_q  <= a2_q;
                            arg3_q  <= a3_q;
                            arg4_q  <= a4_q;
                            cnt_q   <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                S_ISSUE: begin
                    ce_q      <= 1'b1;
                    arg0_q    <= op_char(op_q) & 8'hDF;
                    arg1_q    <= a1_q;
                    arg2_q    <= a2_q;
                    arg3_q    <= a3_q;
                    arg4_q    <= a4_q;
                    done_q    <= 1'b1;
                    resp_id_q <= 3'(gnt_q);
                    state_q   <= S_IDLE;
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nvm_cmd_scheduler.sv
// Directed, cycle-exact bench for nvm_cmd_scheduler (NUM_REQ=4, RESP_MASK=2,
// RESP_WAIT=6, MAX_RETRY=3). Inputs change and outputs are sampled 1ns after
// each rising edge.
module tb_nvm_cmd_scheduler;
    logic clk = 1'b0;
    logic reset;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] lo_tab [4] = '{8'h6C, 8'h77, 8'h72, 8'h63};
    logic [7:0] up_tab [4] = '{8'h4C, 8'h57, 8'h52, 8'h43};

    nvm_cmd_scheduler_if #(.NUM_REQ(4)) bus ();

    nvm_cmd_scheduler #(
        .NUM_REQ   (4),
        .RESP_MASK (2),
        .RESP_WAIT (6),
        .MAX_RETRY (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [1:0] op, input logic [31:0] a1,
                           input logic [31:0] a2, input logic [31:0] a3, input logic [7:0] a4);
        bus.req_op[2*i +: 2]    = op;
        bus.req_arg1[32*i +: 32] = a1;
        bus.req_arg2[32*i +: 32] = a2;
        bus.req_arg3[32*i +: 32] = a3;
        bus.req_arg4[8*i +: 8]   = a4;
    endtask

    task automatic chk_quiet(input string tag);
        chk(tag, {29'd0, bus.command_enable, bus.done_valid, bus.err_valid}, 32'd0);
    endtask

    initial begin
        reset            = 1'b1;
        bus.req_valid    = '0;
        bus.req_op       = '0;
        bus.req_arg1     = '0;
        bus.req_arg2     = '0;
        bus.req_arg3     = '0;
        bus.req_arg4     = '0;
        bus.is_issuable  = 1'b0;
        tick();
        tick();

        // reset state
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_ce",    bus.command_enable, 0);
        chk("rst_arg0",  bus.arg0, 0);
        chk("rst_arg1",  bus.arg1, 0);
        chk("rst_arg4",  bus.arg4, 0);
        chk("rst_done",  bus.done_valid, 0);
        chk("rst_err",   bus.err_valid, 0);
        chk("rst_rid",   bus.resp_id, 0);
        reset = 1'b0;

        // T1: single read from requester 0, issuable 3 cycles after query
        set_req(0, 2'd2, 32'h0000_1000, 32'h0, 32'h0, 8'h01);
        bus.req_valid = 4'b0001;
        tick();
        chk("t1_ready", bus.req_ready, 32'h1);
        bus.req_valid = '0;
        tick();
        chk("t1_q_ce",   bus.command_enable, 1);
        chk("t1_q_op",   bus.arg0, 32'h72);
        chk("t1_q_a1",   bus.arg1, 32'h1000);
        chk("t1_q_a2",   bus.arg2, 0);
        chk("t1_q_a3",   bus.arg3, 0);
        chk("t1_q_a4",   bus.arg4, 32'h01);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk_quiet("t1_gap");
            chk("t1_gap_arg0", bus.arg0, 0);
        end
        bus.is_issuable = 1'b1;
        tick();
        chk_quiet("t1_gap2");
        tick();
        chk("t1_i_ce",   bus.command_enable, 1);
        chk("t1_i_op",   bus.arg0, 32'h52);
        chk("t1_i_a1",   bus.arg1, 32'h1000);
        chk("t1_i_a4",   bus.arg4, 32'h01);
        chk("t1_i_done", bus.done_valid, 1);
        chk("t1_i_rid",  bus.resp_id, 0);
        bus.is_issuable = 1'b0;
        tick();
        chk_quiet("t1_after");
        chk("t1_after_arg0", bus.arg0, 0);

        // T2: all four requesters valid, answered right after the mask
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_req(i, 2'(i), 32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i),
                    32'hC000_0000 + 32'(i), 8'h10 + 8'(i));
        end
        bus.req_valid   = 4'hF;
        bus.is_issuable = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t2_ready", bus.req_ready, 32'h1 << (k % 4));
            tick();
            chk("t2_q_op", bus.arg0, lo_tab[k % 4]);
            chk("t2_q_a1", bus.arg1, 32'hA000_0000 + 32'(k % 4));
            chk("t2_q_a4", bus.arg4, 32'h10 + 32'(k % 4));
            for (int c = 0; c < 3; c++) begin
                tick();
                chk_quiet("t2_gap");
                chk("t2_gap_ready", bus.req_ready, 0);
            end
            tick();
            chk("t2_i_op",   bus.arg0, up_tab[k % 4]);
            chk("t2_i_done", bus.done_valid, 1);
            chk("t2_i_rid",  bus.resp_id, 32'(k % 4));
        end
        bus.req_valid   = '0;
        bus.is_issuable = 1'b0;

        // T3: never issuable, requester 2 write is dropped after 4 queries
        do_reset();
        set_req(2, 2'd1, 32'h2222_0000, 32'h0000_3333, 32'h4444_4444, 8'h55);
        set_req(0, 2'd0, 32'h0000_00AB, 32'h0, 32'h0, 8'h0C);
        bus.req_valid = 4'b0100;
        tick();
        chk("t3_ready", bus.req_ready, 32'h4);
        bus.req_valid = '0;
        for (int q = 0; q < 4; q++) begin
            tick();
            chk("t3_q_ce", bus.command_enable, 1);
            chk("t3_q_op", bus.arg0, 32'h77);
            chk("t3_q_a3", bus.arg3, 32'h4444_4444);
            for (int c = 0; c < 5; c++) begin
                tick();
                chk_quiet("t3_gap");
            end
        end
        tick();
        chk("t3_err",  bus.err_valid, 1);
        chk("t3_rid",  bus.resp_id, 2);
        chk("t3_ce",   bus.command_enable, 0);
        chk("t3_done", bus.done_valid, 0);
        tick();
        chk_quiet("t3_idle");
        bus.req_valid = 4'b0001;
        tick();
        chk("t3_wrap_ready", bus.req_ready, 32'h1);
        bus.req_valid = '0;

        // T4: is_issuable high from reset must be masked after the query
        bus.is_issuable = 1'b1;
        do_reset();
        set_req(1, 2'd0, 32'h1111_1111, 32'h0, 32'h0, 8'hAA);
        bus.req_valid = 4'b0010;
        tick();
        chk("t4_ready", bus.req_ready, 32'h2);
        bus.req_valid = '0;
        tick();
        chk("t4_q_ce", bus.command_enable, 1);
        chk("t4_q_op", bus.arg0, 32'h6C);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk_quiet("t4_mask");
        end
        tick();
        chk("t4_i_ce",   bus.command_enable, 1);
        chk("t4_i_op",   bus.arg0, 32'h4C);
        chk("t4_i_done", bus.done_valid, 1);
        chk("t4_i_rid",  bus.resp_id, 1);
        bus.is_issuable = 1'b0;
        tick();

        // T5: answered on the third query, requester 3 cmd
        set_req(3, 2'd3, 32'hDEAD_BEEF, 32'h0123_4567, 32'h89AB_CDEF, 8'h7E);
        bus.req_valid = 4'b1000;
        tick();
        chk("t5_ready", bus.req_ready, 32'h8);
        bus.req_valid = '0;
        for (int q = 0; q < 3; q++) begin
            tick();
            chk("t5_q_ce", bus.command_enable, 1);
            chk("t5_q_op", bus.arg0, 32'h63);
            chk("t5_q_a1", bus.arg1, 32'hDEAD_BEEF);
            if (q < 2) begin
                for (int c = 0; c < 5; c++) begin
                    tick();
                    chk_quiet("t5_gap");
                end
            end
        end
        bus.is_issuable = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk_quiet("t5_mask");
        end
        tick();
        chk("t5_i_ce",   bus.command_enable, 1);
        chk("t5_i_op",   bus.arg0, 32'h43);
        chk("t5_i_a2",   bus.arg2, 32'h0123_4567);
        chk("t5_i_done", bus.done_valid, 1);
        chk("t5_i_err",  bus.err_valid, 0);
        chk("t5_i_rid",  bus.resp_id, 3);
        bus.is_issuable = 1'b0;
        tick();
        chk_quiet("t5_after");

        // T6: reset during WAIT with requester 1 in flight
        set_req(1, 2'd2, 32'h5555_0000, 32'h0, 32'h0, 8'h33);
        bus.req_valid = 4'b0010;
        tick();
        chk("t6_ready", bus.req_ready, 32'h2);
        bus.req_valid = '0;
        tick();
        chk("t6_q_op", bus.arg0, 32'h72);
        tick();
        bus.is_issuable = 1'b1;
        bus.req_valid   = 4'b0011;
        reset           = 1'b1;
        tick();
        chk("t6_rst_ready", bus.req_ready, 0);
        chk("t6_rst_ce",    bus.command_enable, 0);
        chk("t6_rst_arg0",  bus.arg0, 0);
        chk("t6_rst_arg1",  bus.arg1, 0);
        chk("t6_rst_arg4",  bus.arg4, 0);
        chk("t6_rst_done",  bus.done_valid, 0);
        chk("t6_rst_err",   bus.err_valid, 0);
        chk("t6_rst_rid",   bus.resp_id, 0);
        reset = 1'b0;
        tick();
        chk("t6_first_grant", bus.req_ready, 32'h1);
        chk_quiet("t6_grant_quiet");
        bus.req_valid = '0;
        tick();
        chk("t6_q_op0", bus.arg0, 32'h6C);
        chk("t6_q_a1",  bus.arg1, 32'h0000_00AB);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk_quiet("t6_mask");
        end
        tick();
        chk("t6_i_op",   bus.arg0, 32'h4C);
        chk("t6_i_done", bus.done_valid, 1);
        chk("t6_i_rid",  bus.resp_id, 0);
        bus.is_issuable = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
